mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Data-side memory-map bridge between the single-cycle CPU's data port and its storage/peripherals. It decodes the CPU's ALU-computed address, then steers writes to an internal word RAM, a countdown timer, or an LED register. It returns read data combinationally, so the CPU's same-cycle load semantics are kept. The timer runs a four-state counting FSM and raises a sticky interrupt line.

## Interface
- DM_AW, default 10: log2 of data RAM depth in 32-bit words.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  32  byte address from CPU ALU output; addr[1:0] ignored.
- wdata  in  32  store data from CPU.
- we  in  1  store strobe from CPU; write committed on the clk edge.
- rdata  out  32  load data to CPU, combinational from addr.
- sw_in  in  16  asynchronous switch inputs.
- led_out  out  16  LED register.
- irq  out  1  timer interrupt, registered, sticky.

## Operation
- Address map (word aligned):
  - RAM: addr < 4*2^DM_AW, indexed by addr[DM_AW+1:2].
  - 0x7F00: CTRL, r/w.
  - 0x7F04: PRESET, r/w.
  - 0x7F08: COUNT, read-only.
  - 0x7F10: LED, r/w, bits [15:0].
  - 0x7F14: SW, read-only.
  - All other addresses: read 0, write ignored.
- Register read formats:
  - CTRL reads {28'b0, IM, MODE[1:0], EN}.
  - LED and SW read zero-extended.
  - Writes to COUNT and SW are ignored.
- MODE encoding: 00 one-shot, 01 auto-reload, 1x treated as one-shot.
- RAM:
  - Read is asynchronous.
  - A write updates RAM on the edge; a same-cycle read of the same word returns the old data.
  - Contents are not cleared by rst.
- SW path: sw_in passes through a 2-flop synchronizer (reset 0), and SW reads return the second flop.
- Timer FSM (states IDLE, LOAD, CNT, INT):
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT==0, go to INT and set irq<=1 when IM=1. Else COUNT <= COUNT-1.
  - INT, one-shot: EN <= 0; go to IDLE.
  - INT, auto-reload: go to LOAD.
- Any CPU write to CTRL clears irq. A CTRL write with IM=0 also prevents irq from setting.
- Simultaneous events:
  - A CPU CTRL write and the INT-state EN clear on the same edge: the CPU write wins (EN takes wdata[0]).
  - A CTRL write on the same edge that irq would set: irq ends at 0.
  - A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
  - PRESET=0 runs LOAD -> CNT -> INT with no decrement.
- Reset (asynchronous, any time including mid-count):
  - CTRL, PRESET, COUNT, LED, sync flops and irq all go to 0; state goes to IDLE.
  - led_out=0, irq=0.
  - rdata then reflects the reset register values (RAM reads unaffected).

## Timing
- rdata: zero-cycle combinational path from addr; no stall or handshake. Every access completes in the CPU's single cycle.
- Register writes are visible to reads in the cycle after the write edge.
- Timer latency, with the CTRL write setting EN=1 at edge E0 and PRESET=N:
  - E1: enter LOAD.
  - E2: COUNT=N, state CNT.
  - E2+k: COUNT=N-k, for k=1..N.
  - E(N+3): state INT, irq=1 (if IM).
- Auto-reload period is N+3 cycles: INT->LOAD->CNT, and COUNT=N again at E(N+5).
- One-shot: EN reads 0 from E(N+4).
- Clearing EN at edge Ec during CNT: state IDLE at Ec+1, COUNT frozen at its Ec+1 value.
- SW read reflects an sw_in change after 2 edges.

## Test plan
- Reset/defaults: assert rst mid-cycle -> immediately led_out=0, irq=0, reads of 0x7F00/04/08/10 return 0.
- RAM: store 0xDEADBEEF to 0x0000_0010, load 0x10 next cycle -> 0xDEADBEEF. Same-cycle load before the edge -> old value. Load 0x7F0C -> 0.
- One-shot timer: PRESET=5, CTRL=0x9 (EN, IM) -> irq rises exactly 8 edges after the CTRL write edge, then CTRL reads 0x8. Write CTRL=0 -> irq=0.
- Auto-reload: PRESET=3, CTRL=0xB -> COUNT reaches 0 repeatedly, with INT states 6 cycles apart. A PRESET=7 write mid-count -> next reload loads 7.
- Collision and disable: CTRL write with EN=1 on the INT edge in one-shot mode -> EN stays 1 and irq=0. EN=0 write during CNT at COUNT=4 -> COUNT holds at 3.
- IO: write LED=0x1234 -> led_out=0x1234 next cycle. Set sw_in=0xA5A5 -> SW read returns 0xA5A5 after 2 edges, old value before.

Source files
------------

// File: rtl/mmio_bridge.sv
// Data-side memory-map bridge: word RAM, countdown timer with sticky interrupt,
// LED register and synchronized switch inputs behind one CPU load/store port.
module mmio_bridge #(
  parameter int DM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        irq
);

  localparam int          RAM_WORDS = 1 << DM_AW;
  localparam logic [29:0] CTRL_WA   = 30'h0000_1FC0;
  localparam logic [29:0] PRESET_WA = 30'h0000_1FC1;
  localparam logic [29:0] COUNT_WA  = 30'h0000_1FC2;
  localparam logic [29:0] LED_WA    = 30'h0000_1FC4;
  localparam logic [29:0] SW_WA     = 30'h0000_1FC5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  logic [31:0]      mem_r [0:RAM_WORDS-1];
  logic [29:0]      word_s;
  logic [DM_AW-1:0] ram_idx_s;
  logic             ram_hit_s;
  logic             ctrl_we_s;
  logic             preset_we_s;
  logic             led_we_s;
  logic             unused_s;

  state_t      state_r, state_s;
  logic        en_r, en_s;
  logic [1:0]  mode_r;
  logic        im_r;
  logic [31:0] preset_r;
  logic [31:0] count_r, count_s;
  logic        irq_r, irq_s;
  logic [15:0] led_r;
  logic [15:0] sw_meta_r, sw_sync_r;

  assign word_s      = addr[31:2];
  assign ram_idx_s   = addr[DM_AW+1:2];
  assign ram_hit_s   = (addr[31:DM_AW+2] == {(30-DM_AW){1'b0}});
  assign ctrl_we_s   = we & ~ram_hit_s & (word_s == CTRL_WA);
  assign preset_we_s = we & ~ram_hit_s & (word_s == PRESET_WA);
  assign led_we_s    = we & ~ram_hit_s & (word_s == LED_WA);
  assign unused_s    = &{1'b0, addr[1:0]};

  assign led_out = led_r;
  assign irq     = irq_r;

  // RAM write port; contents deliberately survive rst
  always_ff @(posedge clk) begin
    if (we && ram_hit_s) begin
      mem_r[ram_idx_s] <= wdata;
    end
  end

  // Combinational read mux keeps the CPU's same-cycle load semantics
  always_comb begin
    rdata = 32'd0;
    if (ram_hit_s) begin
      rdata = mem_r[ram_idx_s];
    end else begin
      case (word_s)
        CTRL_WA:   rdata = {28'd0, im_r, mode_r, en_r};
        PRESET_WA: rdata = preset_r;
        COUNT_WA:  rdata = count_r;
        LED_WA:    rdata = {16'd0, led_r};
        SW_WA:     rdata = {16'd0, sw_sync_r};
        default:   rdata = 32'd0;
      endcase
    end
  end

  // Timer next-state logic; a CPU CTRL write overrides both EN clear and irq set
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    en_s    = ctrl_we_s ? wdata[0] : en_r;
    irq_s   = ctrl_we_s ? 1'b0 : irq_r;
    case (state_r)
      ST_IDLE: begin
        if (en_r) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_s = preset_r;
        state_s = ST_CNT;
      end
      ST_CNT: begin
        if (!en_r) begin
          state_s = ST_IDLE;
        end else if (count_r == 32'd0) begin
          state_s = ST_INT;
          if (im_r && !ctrl_we_s) begin
            irq_s = 1'b1;
          end else begin
            irq_s = ctrl_we_s ? 1'b0 : irq_r;
          end
        end else begin
          count_s = count_r - 32'd1;
        end
      end
      ST_INT: begin
        if (mode_r == 2'b01) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
          en_s    = ctrl_we_s ? wdata[0] : 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Timer state, control fields and interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      en_r     <= 1'b0;
      mode_r   <= 2'b00;
      im_r     <= 1'b0;
      preset_r <= 32'd0;
      count_r  <= 32'd0;
      irq_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      en_r    <= en_s;
      count_r <= count_s;
      irq_r   <= irq_s;
      if (ctrl_we_s) begin
        mode_r <= wdata[2:1];
        im_r   <= wdata[3];
      end
      if (preset_we_s) begin
        preset_r <= wdata;
      end
    end
  end

  // LED register and two-flop switch synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r     <= 16'd0;
      sw_meta_r <= 16'd0;
      sw_sync_r <= 16'd0;
    end else begin
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
      if (led_we_s) begin
        led_r <= wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: expected values queued when stimulus is
// driven, popped and compared when the DUT output is sampled.
module tb_mmio_bridge;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_HOLE   = 32'h0000_7F0C;
  localparam logic [31:0] A_LED    = 32'h0000_7F10;
  localparam logic [31:0] A_SW     = 32'h0000_7F14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic [15:0] sw_in = 16'd0;
  logic [15:0] led_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  int ar_cnt [20] = '{0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0, 7};

  mmio_bridge #(.DM_AW(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .sw_in   (sw_in),
    .led_out (led_out),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t x;
    x = sb_q.pop_front();
    checks++;
    assert (obs === x.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    we   = 1'b0;
    addr = a;
    push_exp(tag, e);
    #1;
    check_obs(rdata);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push_exp(tag, e);
    check_obs(obs);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    rd(A_CTRL, 32'd0, "por_ctrl");

    // load non-zero state, then reset mid-count
    wr(A_LED, 32'h0000_FFFF);
    wr(A_PRESET, 32'h0000_0055);
    wr(A_CTRL, 32'h0000_000F);
    step();
    step();
    rd(A_COUNT, 32'h0000_0055, "pre_rst_count");
    chk("pre_rst_led", {16'd0, led_out}, 32'h0000_FFFF);
    rst = 1'b1;
    #1;
    chk("rst_led", {16'd0, led_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_PRESET, 32'd0, "rst_preset");
    rd(A_COUNT, 32'd0, "rst_count");
    rd(A_LED, 32'd0, "rst_ledreg");
    rst = 1'b0;
    step();

    // RAM: same-cycle read returns old word, next cycle returns new
    wr(32'h0000_0010, 32'h1111_1111);
    addr  = 32'h0000_0010;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    push_exp("ram_same_cycle", 32'h1111_1111);
    #1;
    check_obs(rdata);
    step();
    we = 1'b0;
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_next_cycle");
    rd(A_HOLE, 32'd0, "hole_read");
    wr(A_HOLE, 32'hFFFF_FFFF);
    rd(A_HOLE, 32'd0, "hole_after_write");
    wr(A_COUNT, 32'd5);
    rd(A_COUNT, 32'd0, "count_ro");

    // LED and synchronized switches
    wr(A_LED, 32'h0000_1234);
    chk("led_out", {16'd0, led_out}, 32'h0000_1234);
    rd(A_LED, 32'h0000_1234, "led_read");
    sw_in = 16'hA5A5;
    rd(A_SW, 32'd0, "sw_edge0");
    step();
    rd(A_SW, 32'd0, "sw_edge1");
    step();
    rd(A_SW, 32'h0000_A5A5, "sw_edge2");

    // one-shot: PRESET=5, irq exactly 8 edges after the CTRL write edge
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h0000_0009);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j >= 2) begin
        rd(A_COUNT, 32'(7 - j), "os_count");
      end
      chk("os_irq_low", {31'd0, irq}, 32'd0);
    end
    step();
    chk("os_irq_rise", {31'd0, irq}, 32'd1);
    rd(A_CTRL, 32'h0000_0009, "os_ctrl_int");
    step();
    rd(A_CTRL, 32'h0000_0008, "os_ctrl_done");
    chk("os_irq_sticky", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'd0);
    chk("os_irq_clear", {31'd0, irq}, 32'd0);

    // auto-reload: PRESET=3, INT every 6 edges, PRESET=7 written mid-count
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h0000_000B);
    for (int j = 1; j <= 20; j++) begin
      if (j == 7) begin
        addr = A_CTRL; wdata = 32'h0000_000B; we = 1'b1;
      end else if (j == 15) begin
        addr = A_PRESET; wdata = 32'd7; we = 1'b1;
      end else begin
        we = 1'b0;
      end
      step();
      we = 1'b0;
      rd(A_COUNT, 32'(ar_cnt[j-1]), "ar_count");
      chk("ar_irq", {31'd0, irq}, ((j == 6) || (j >= 12)) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'd0);
    chk("ar_irq_clear", {31'd0, irq}, 32'd0);

    // CTRL write on the INT edge beats the one-shot EN clear and irq
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h0000_0009);
    repeat (4) step();
    chk("col_irq_low", {31'd0, irq}, 32'd0);
    step();
    chk("col_irq_set", {31'd0, irq}, 32'd1);
    rd(A_COUNT, 32'd0, "col_count_zero");
    wr(A_CTRL, 32'h0000_0009);
    rd(A_CTRL, 32'h0000_0009, "col_en_kept");
    chk("col_irq_cleared", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'd0);
    repeat (3) step();

    // disable during CNT: COUNT freezes one below the value seen at the write
    wr(A_PRESET, 32'd6);
    wr(A_CTRL, 32'h0000_0001);
    repeat (4) step();
    rd(A_COUNT, 32'd4, "dis_count_before");
    wr(A_CTRL, 32'd0);
    rd(A_COUNT, 32'd3, "dis_count_e1");
    step();
    rd(A_COUNT, 32'd3, "dis_count_e2");
    step();
    rd(A_COUNT, 32'd3, "dis_count_e3");
    rd(A_CTRL, 32'd0, "dis_ctrl");

    // reset leaves RAM contents intact
    rst = 1'b1;
    #1;
    rd(32'h0000_0010, 32'hDEAD_BEEF, "rst_ram_kept");
    chk("rst2_led", {16'd0, led_out}, 32'd0);
    rd(A_SW, 32'd0, "rst2_sw");
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
